// File: rtl/add_sub_if.sv
// add_sub_if: operand/result bundle for add_sub; ovf exists only when ADD_SUB_OVF_EN is defined.
interface add_sub_if #(
    parameter int WIDTH = 4
) ();
    logic             m;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic [WIDTH-1:0] s;
    logic             cout;
`ifdef ADD_SUB_OVF_EN
    logic             ovf;
    modport master (output m, a, b, input s, cout, ovf);
    modport slave  (input m, a, b, output s, cout, ovf);
`else
    modport master (output m, a, b, input s, cout);
    modport slave  (input m, a, b, output s, cout);
`endif
endinterface

// File: rtl/add_sub.sv
// add_sub: registered ripple-carry adder/subtractor, one-cycle latency.
// ADD_SUB_OVF_EN adds a registered signed-overflow flag.
module add_sub #(
    parameter int WIDTH = 4
) (
    input  logic      clk,
    input  logic      rst,
    add_sub_if.slave  bus
);
    logic [WIDTH:0]   c;
    logic [WIDTH-1:0] sum;
    logic [WIDTH-1:0] b_eff;

    // subtract reuses the adder as a + ~b + 1, with m as the carry-in
    assign c[0] = bus.m;

    for (genvar i = 0; i < WIDTH; i++) begin : g_fa
        assign b_eff[i] = bus.b[i] ^ bus.m;
        assign sum[i]   = bus.a[i] ^ b_eff[i] ^ c[i];
        assign c[i+1]   = (bus.a[i] & b_eff[i]) | (c[i] & (bus.a[i] ^ b_eff[i]));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus.s    <= '0;
            bus.cout <= 1'b0;
`ifdef ADD_SUB_OVF_EN
            bus.ovf  <= 1'b0;
`endif
        end else begin
            bus.s    <= sum;
            bus.cout <= c[WIDTH];
`ifdef ADD_SUB_OVF_EN
            bus.ovf  <= c[WIDTH] ^ c[WIDTH-1];
`endif
        end
    end
endmodule

// File: tb/tb_add_sub.sv
// tb_add_sub: directed, exhaustive and random checks of add_sub against an arithmetic model.
module tb_add_sub;
    localparam int W = 4;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_fails  = 0;

    add_sub_if #(.WIDTH(W)) bus ();

    add_sub #(.WIDTH(W)) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input int got, input int exp);
        n_checks++;
        if (got !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    // reference: plain integer arithmetic, unsigned for s/cout, signed range for ovf
    task automatic model(input logic mm, input int ua, input int ub,
                         output int es, output int ec, output int eo);
        int sa, sb, sr;
        sa = (ua >= (1 << (W - 1))) ? ua - (1 << W) : ua;
        sb = (ub >= (1 << (W - 1))) ? ub - (1 << W) : ub;
        if (!mm) begin
            es = (ua + ub) % (1 << W);
            ec = (ua + ub) >= (1 << W) ? 1 : 0;
            sr = sa + sb;
        end else begin
            es = (ua - ub + (1 << W)) % (1 << W);
            ec = (ua >= ub) ? 1 : 0;
            sr = sa - sb;
        end
        eo = (sr > (1 << (W - 1)) - 1 || sr < -(1 << (W - 1))) ? 1 : 0;
    endtask

    task automatic drive(input logic rr, input logic mm, input int ua, input int ub);
        @(negedge clk);
        rst   = rr;
        bus.m = mm;
        bus.a = ua[W-1:0];
        bus.b = ub[W-1:0];
        @(posedge clk);
        #1;
    endtask

    task automatic go(input string tag, input logic mm, input int ua, input int ub);
        int es, ec, eo;
        drive(1'b0, mm, ua, ub);
        model(mm, ua, ub, es, ec, eo);
        check({tag, ".s"}, int'(bus.s), es);
        check({tag, ".cout"}, int'(bus.cout), ec);
`ifdef ADD_SUB_OVF_EN
        check({tag, ".ovf"}, int'(bus.ovf), eo);
`endif
    endtask

    task automatic reset_cycle(input string tag);
        drive(1'b1, 1'($urandom), int'($urandom_range(0, (1 << W) - 1)),
              int'($urandom_range(0, (1 << W) - 1)));
        check({tag, ".s"}, int'(bus.s), 0);
        check({tag, ".cout"}, int'(bus.cout), 0);
`ifdef ADD_SUB_OVF_EN
        check({tag, ".ovf"}, int'(bus.ovf), 0);
`endif
    endtask

    initial begin
        bus.m = 1'b0;
        bus.a = '0;
        bus.b = '0;
        reset_cycle("rst0");
        reset_cycle("rst1");
        go("rel", 1'b0, 4'b0100, 4'b0011);
        // directed cases, back-to-back with operands changing every cycle
        go("add0", 1'b0, 4'b1000, 4'b0111);
        go("add1", 1'b0, 4'b0111, 4'b0001);
        go("add2", 1'b0, 4'b1111, 4'b0001);
        go("sub0", 1'b1, 4'b1000, 4'b0011);
        go("sub1", 1'b1, 4'b1001, 4'b0100);
        go("sub2", 1'b1, 4'b0001, 4'b0001);
        go("bor0", 1'b1, 4'b0000, 4'b0001);
        go("add3", 1'b0, 4'b1111, 4'b0001);
        // fixed literal expectations from the test plan, independent of the model
        go("lit", 1'b1, 4'b0000, 4'b0001);
        check("lit.s_ones", int'(bus.s), 15);
        go("lit2", 1'b0, 4'b0111, 4'b0001);
        check("lit2.s", int'(bus.s), 8);
        // reset mid-stream discards that edge's result
        go("pre", 1'b0, 4'b0101, 4'b0101);
        reset_cycle("mid");
        go("post", 1'b1, 4'b0110, 4'b0010);
        for (int mm = 0; mm < 2; mm++)
            for (int ua = 0; ua < (1 << W); ua++)
                for (int ub = 0; ub < (1 << W); ub++)
                    go("exh", 1'(mm), ua, ub);
        for (int k = 0; k < 200; k++)
            go("rnd", 1'($urandom), int'($urandom_range(0, (1 << W) - 1)),
               int'($urandom_range(0, (1 << W) - 1)));
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end
endmodule
